// File: rtl/lcd_cmd_writer.sv
// HD44780 4-bit command/data writer: runs the post-init configuration bytes, then serves host byte writes.
// Optional build macro LCD_CURSOR_BLINK_EN selects Display On = 0x0F instead of 0x0C.
module lcd_cmd_writer #(
    parameter int T_SETUP      = 2,
    parameter int T_E_HIGH     = 12,
    parameter int T_NIBBLE_GAP = 50,
    parameter int T_CMD_WAIT   = 2000,
    parameter int T_CLEAR_WAIT = 82000,
    parameter int CNT_W        = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       cfg_done,
    output logic [3:0] SF_D,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW
);

`ifdef LCD_CURSOR_BLINK_EN
    localparam logic [7:0] DISPLAY_ON = 8'h0F;
`else
    localparam logic [7:0] DISPLAY_ON = 8'h0C;
`endif

    localparam logic [3:0] S_WAIT_INIT = 4'd0;
    localparam logic [3:0] S_LOAD      = 4'd1;
    localparam logic [3:0] S_UP_SETUP  = 4'd2;
    localparam logic [3:0] S_UP_E      = 4'd3;
    localparam logic [3:0] S_UP_HOLD   = 4'd4;
    localparam logic [3:0] S_GAP       = 4'd5;
    localparam logic [3:0] S_LO_SETUP  = 4'd6;
    localparam logic [3:0] S_LO_E      = 4'd7;
    localparam logic [3:0] S_LO_HOLD   = 4'd8;
    localparam logic [3:0] S_WAIT      = 4'd9;
    localparam logic [3:0] S_READY     = 4'd10;

    localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

    logic [3:0]       r_state, w_state_next;
    logic [CNT_W-1:0] r_timer, w_timer_next;
    logic [2:0]       r_cfg_idx, w_cfg_idx_next;
    logic             r_cfg_done, w_cfg_done_next;
    logic [7:0]       r_byte, w_byte_next;
    logic             r_rs, w_rs_next;
    logic [3:0]       r_sf_d, w_sf_d_next;
    logic             r_lcd_e, w_lcd_e_next;
    logic             r_lcd_rs, w_lcd_rs_next;
    logic             r_wr_ready, w_wr_ready_next;
    logic [7:0]       w_cfg_byte;
    logic [CNT_W-1:0] w_dur_m1;
    logic             w_last;

    always_comb begin
        case (r_cfg_idx)
            3'd0:    w_cfg_byte = 8'h28;
            3'd1:    w_cfg_byte = 8'h06;
            3'd2:    w_cfg_byte = DISPLAY_ON;
            default: w_cfg_byte = 8'h01;
        endcase
    end

    // Clear (RS=0, 0x01) needs the long post-command wait.
    always_comb begin
        case (r_state)
            S_UP_SETUP, S_LO_SETUP: w_dur_m1 = CNT_W'(T_SETUP - 1);
            S_UP_E, S_LO_E:         w_dur_m1 = CNT_W'(T_E_HIGH - 1);
            S_GAP:                  w_dur_m1 = CNT_W'(T_NIBBLE_GAP - 1);
            S_WAIT:                 w_dur_m1 = (!r_rs && r_byte == 8'h01) ?
                                               CNT_W'(T_CLEAR_WAIT - 1) : CNT_W'(T_CMD_WAIT - 1);
            default:                w_dur_m1 = '0;
        endcase
    end

    assign w_last = (r_timer == w_dur_m1);

    always_comb begin
        w_state_next    = r_state;
        w_cfg_idx_next  = r_cfg_idx;
        w_cfg_done_next = r_cfg_done;
        w_byte_next     = r_byte;
        w_rs_next       = r_rs;
        case (r_state)
            S_WAIT_INIT: if (enable) w_state_next = S_LOAD;
            S_LOAD: begin
                if (r_cfg_idx < 3'd4) begin
                    w_byte_next    = w_cfg_byte;
                    w_rs_next      = 1'b0;
                    w_cfg_idx_next = r_cfg_idx + 3'd1;
                    w_state_next   = S_UP_SETUP;
                end else begin
                    w_cfg_done_next = 1'b1;
                    w_state_next    = S_READY;
                end
            end
            S_UP_SETUP: if (w_last) w_state_next = S_UP_E;
            S_UP_E:     if (w_last) w_state_next = S_UP_HOLD;
            S_UP_HOLD:  w_state_next = S_GAP;
            S_GAP:      if (w_last) w_state_next = S_LO_SETUP;
            S_LO_SETUP: if (w_last) w_state_next = S_LO_E;
            S_LO_E:     if (w_last) w_state_next = S_LO_HOLD;
            S_LO_HOLD:  w_state_next = S_WAIT;
            S_WAIT: begin
                // The final config byte goes straight to READY so ready lines up with the end of its wait.
                if (w_last) begin
                    if (r_cfg_done) begin
                        w_state_next = S_READY;
                    end else if (r_cfg_idx < 3'd4) begin
                        w_state_next = S_LOAD;
                    end else begin
                        w_cfg_done_next = 1'b1;
                        w_state_next    = S_READY;
                    end
                end
            end
            S_READY: begin
                if (wr_valid) begin
                    w_byte_next  = wr_data;
                    w_rs_next    = wr_rs;
                    w_state_next = S_UP_SETUP;
                end
            end
            default: w_state_next = S_WAIT_INIT;
        endcase
        if (!enable) begin
            w_state_next    = S_WAIT_INIT;
            w_cfg_idx_next  = 3'd0;
            w_cfg_done_next = 1'b0;
        end
        w_timer_next = (w_state_next == r_state) ? r_timer + TIMER_ONE : '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        w_sf_d_next     = 4'h0;
        w_lcd_e_next    = 1'b0;
        w_lcd_rs_next   = 1'b0;
        case (w_state_next)
            S_UP_SETUP, S_UP_HOLD: begin
                w_sf_d_next   = w_byte_next[7:4];
                w_lcd_rs_next = w_rs_next;
            end
            S_UP_E: begin
                w_sf_d_next   = w_byte_next[7:4];
                w_lcd_rs_next = w_rs_next;
                w_lcd_e_next  = 1'b1;
            end
            S_LO_SETUP, S_LO_HOLD: begin
                w_sf_d_next   = w_byte_next[3:0];
                w_lcd_rs_next = w_rs_next;
            end
            S_LO_E: begin
                w_sf_d_next   = w_byte_next[3:0];
                w_lcd_rs_next = w_rs_next;
                w_lcd_e_next  = 1'b1;
            end
            S_GAP, S_WAIT: w_lcd_rs_next = w_rs_next;
            default: ;
        endcase
        w_wr_ready_next = (w_state_next == S_READY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_WAIT_INIT;
            r_timer    <= '0;
            r_cfg_idx  <= 3'd0;
            r_cfg_done <= 1'b0;
            r_byte     <= 8'h00;
            r_rs       <= 1'b0;
            r_sf_d     <= 4'h0;
            r_lcd_e    <= 1'b0;
            r_lcd_rs   <= 1'b0;
            r_wr_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_cfg_idx  <= w_cfg_idx_next;
            r_cfg_done <= w_cfg_done_next;
            r_byte     <= w_byte_next;
            r_rs       <= w_rs_next;
            r_sf_d     <= w_sf_d_next;
            r_lcd_e    <= w_lcd_e_next;
            r_lcd_rs   <= w_lcd_rs_next;
            r_wr_ready <= w_wr_ready_next;
        end
    end

    assign SF_D     = r_sf_d;
    assign LCD_E    = r_lcd_e;
    assign LCD_RS   = r_lcd_rs;
    assign LCD_RW   = 1'b0;
    assign wr_ready = r_wr_ready;
    assign cfg_done = r_cfg_done;

endmodule

// File: doc/lcd_cmd_writer.md
Name: lcd_cmd_writer

Overview:
Downstream of the LCD power-on initialisation FSM on the Spartan-3E character LCD (4-bit interface, 50 MHz clk). Waits for the init FSM's `enable`, then issues the configuration sequence: Function Set 0x28, Entry Mode 0x06, Display On 0x0C, Clear 0x01. After that it accepts byte writes through a valid/ready handshake and sends each byte as two nibbles with HD44780-compliant timing. Its outputs are zero while `enable` is low, so the top level ORs them with the init FSM's SF_D[11:8] and LCD_E.

Parameters:
T_SETUP, 2, cycles nibble and RS are stable before LCD_E rises
T_E_HIGH, 12, cycles LCD_E is held high per nibble
T_NIBBLE_GAP, 50, idle cycles between upper-nibble hold and lower-nibble setup (1 us)
T_CMD_WAIT, 2000, wait after lower-nibble hold for a normal byte (40 us)
T_CLEAR_WAIT, 82000, wait after lower-nibble hold for Clear, i.e. RS=0 and byte 0x01 (1.64 ms)
CNT_W, 17, timer width; must hold T_CLEAR_WAIT

Ports:
clk  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-low reset (0 = in reset)
enable  input  1  init-done from the power-on init FSM; level, sticky once high
wr_valid  input  1  host byte-write request
wr_rs  input  1  register select for the byte: 0 = command, 1 = data
wr_data  input  8  byte to write
wr_ready  output  1  block idle and config complete; a write is accepted when wr_valid & wr_ready
cfg_done  output  1  configuration sequence has completed
SF_D  output  4  LCD data nibble; drives SF_D[11:8]
LCD_E  output  1  LCD enable strobe
LCD_RS  output  1  LCD register select
LCD_RW  output  1  always 0 (write only)

Behaviour:
- Reset (async, reset=0): all outputs 0, state WAIT_INIT, cfg index 0, timer 0. Every output is registered.
- States: WAIT_INIT, LOAD, UP_SETUP, UP_E, UP_HOLD, GAP, LO_SETUP, LO_E, LO_HOLD, WAIT, READY.
- WAIT_INIT: all outputs 0. Moves to LOAD on the first clk with enable=1.
- LOAD: latches the next config byte (RS=0) when cfg index < 4. Otherwise sets cfg_done=1 and goes to READY.
- Byte transfer. Cycle 0 is the first cycle after LOAD or after acceptance.
  - UP_SETUP: SF_D = byte[7:4], LCD_RS = rs, LCD_E = 0, for T_SETUP cycles.
  - UP_E: LCD_E = 1 for T_E_HIGH cycles.
  - UP_HOLD: LCD_E = 0, data held 1 cycle.
  - GAP: SF_D = 0, LCD_RS held, for T_NIBBLE_GAP cycles.
  - LO_SETUP, LO_E, LO_HOLD: same as the upper nibble, with byte[3:0].
  - WAIT: SF_D = 0, LCD_E = 0, for T_CLEAR_WAIT cycles if (rs=0 and byte=0x01), else T_CMD_WAIT.
  - After WAIT: LOAD during config, else READY.
- Normal byte: 2080 cycles from cycle 0 until wr_ready=1. Clear: 82080 cycles.
- READY: wr_ready=1.
  - On wr_valid=1, wr_data and wr_rs are captured on that edge and wr_ready drops in the next cycle (cycle 0).
  - wr_valid while wr_ready=0 is ignored, not queued.
- The timer reloads to 0 on every state change. It never wraps, because CNT_W covers the maximum count.
- If enable falls in any state other than WAIT_INIT: return to WAIT_INIT next clk, with outputs, cfg_done and cfg index cleared.
- Reset mid-transfer: LCD_E and all outputs drop asynchronously. After release, the full config sequence reruns once enable=1.

Optional Feature:
LCD_CURSOR_BLINK_EN. When defined, the Display On config byte is 0x0F (display, cursor and blink on). When undefined it is 0x0C (display on, cursor off). No other timing or behaviour changes.

Test Plan:
- reset=0 with enable=1 and wr_valid=1 → SF_D=0, LCD_E=0, LCD_RS=0, wr_ready=0, cfg_done=0 for the whole reset.
- Release reset, enable 0→1 → nibble sequence 2,8,0,6,0,C,0,1 with RS=0. Each LCD_E pulse is exactly 12 cycles, starting 2 cycles after the nibble appears. Upper-to-lower spacing is 50+2 cycles after hold. cfg_done and wr_ready rise 82080 cycles after cycle 0 of 0x01.
- After config, wr_valid=1, wr_rs=1, wr_data=0x41 for 1 cycle → nibbles 0x4 then 0x1 with LCD_RS=1, 2 E pulses, wr_ready back high 2080 cycles later.
- Write 0x01 with wr_rs=1 → 2080-cycle busy. Write 0x01 with wr_rs=0 → 82080-cycle busy. wr_valid held high throughout produces only one transfer per wr_ready window.
- Assert reset during the 5th cycle of an LCD_E pulse → LCD_E=0 in the same cycle. After release, config restarts at 0x28. Separately, drop enable mid-WAIT → WAIT_INIT next clk, outputs 0.
- Build with LCD_CURSOR_BLINK_EN → third config byte nibbles are 0x0, 0xF. Without it → 0x0, 0xC.
